// File: rtl/enc_rr_pkg.sv
// rtl/enc_rr_pkg.sv - shared types, default widths and helpers for the encoder round-robin arbiter
package enc_rr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int ENC_LAT_DEF = 1;

    // Minimum 1 bit so ENC_LAT=0 and two-requester builds keep legal vectors
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int ID_W  = width_of(NUM_REQ_DEF);
    localparam int CNT_W = width_of(ENC_LAT_DEF + 1);

    function automatic logic is_onehot(input logic [31:0] w);
        return (w != 32'd0) && ((w & (w - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/enc_rr_picker.sv
// rtl/enc_rr_picker.sv - combinational round-robin picker, first valid at or after ptr
module enc_rr_picker
    import enc_rr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = width_of(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      ptr,
    output logic               grant_vld,
    output logic [IW-1:0]      grant_idx
);

    int idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/enc_rr_arbiter.sv
// rtl/enc_rr_arbiter.sv - round-robin sequencer sharing one registered encoder; ENC_RR_ONEHOT_CHK_EN adds rsp_err
module enc_rr_arbiter
    import enc_rr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DIN_W   = 4,
    parameter int DOUT_W  = 2,
    parameter int ENC_LAT = 1,
    localparam int IW     = width_of(NUM_REQ),
    localparam int CW     = width_of(ENC_LAT + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*DIN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [DIN_W-1:0]         enc_data_in,
    input  logic [DOUT_W-1:0]        enc_data_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IW-1:0]            rsp_id,
    output logic [DOUT_W-1:0]        rsp_data,
`ifdef ENC_RR_ONEHOT_CHK_EN
    output logic                     busy,
    output logic                     rsp_err
`else
    output logic                     busy
`endif
);

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DIN_W-1:0]  enc_q, enc_d;
    logic [IW-1:0]     id_q, id_d;
    logic [DOUT_W-1:0] data_q, data_d;
    logic              grant_vld;
    logic [IW-1:0]     grant_idx;
    logic [DIN_W-1:0]  win_word;
`ifdef ENC_RR_ONEHOT_CHK_EN
    logic              err_q, err_d;
`endif

    enc_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    assign win_word = req_data[int'(grant_idx)*DIN_W +: DIN_W];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        enc_d     = enc_q;
        id_d      = id_q;
        data_d    = data_q;
        req_ready = '0;
`ifdef ENC_RR_ONEHOT_CHK_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    id_d  = grant_idx;
                    cnt_d = '0;
`ifdef ENC_RR_ONEHOT_CHK_EN
                    // Illegal words bypass the encoder and answer with an error
                    if (!is_onehot(32'(win_word))) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        enc_d   = win_word;
                        err_d   = 1'b0;
                        state_d = RUN;
                    end
`else
                    enc_d   = win_word;
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (cnt_q == CW'(ENC_LAT)) begin
                    data_d  = enc_data_out;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    ptr_d   = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + IW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Keep requesters from seeing a grant while reset is asserted
        if (reset) req_ready = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            enc_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
`ifdef ENC_RR_ONEHOT_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            enc_q   <= enc_d;
            id_q    <= id_d;
            data_q  <= data_d;
`ifdef ENC_RR_ONEHOT_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign enc_data_in = enc_q;
    assign rsp_id      = id_q;
    assign rsp_data    = data_q;
    assign rsp_valid   = (state_q == RESP);
    assign busy        = (state_q != IDLE);
`ifdef ENC_RR_ONEHOT_CHK_EN
    assign rsp_err     = err_q;
`endif

endmodule

// File: tb/tb_enc_rr_arbiter.sv
// tb/tb_enc_rr_arbiter.sv - directed table-driven bench for enc_rr_arbiter with a registered encoder model
module tb_enc_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  enc_in;
    logic [1:0]  enc_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [1:0]  rsp_data;
    logic        busy;
`ifdef ENC_RR_ONEHOT_CHK_EN
    logic        rsp_err;
`endif
    logic [3:0]  words [4];

    always #5 clk = ~clk;

    assign req_data = {words[3], words[2], words[1], words[0]};

    enc_rr_arbiter #(.NUM_REQ(4), .DIN_W(4), .DOUT_W(2), .ENC_LAT(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .enc_data_in  (enc_in),
        .enc_data_out (enc_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
`ifdef ENC_RR_ONEHOT_CHK_EN
        .busy         (busy),
        .rsp_err      (rsp_err)
`else
        .busy         (busy)
`endif
    );

    // Highest set bit wins; zero encodes to 0
    function automatic logic [1:0] enc_fn(input logic [3:0] w);
        if (w[3]) return 2'd3;
        if (w[2]) return 2'd2;
        if (w[1]) return 2'd1;
        return 2'd0;
    endfunction

    always_ff @(posedge clk) enc_out <= enc_fn(enc_in);

    typedef struct {
        logic [3:0] valid;
        int         hold;
        int         exp_id;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs [11];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_grant(output int waited);
        waited = 0;
        while (req_ready == 4'd0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the response handshake
    task automatic run_vec(input vec_t v, input int n);
        int waited;
        req_valid = v.valid;
        rsp_ready = (v.hold == 0);
        #1;
        wait_grant(waited);
        chk($sformatf("v%0d grant_wait", n), 32'(waited), 32'd0);
        chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(4'b0001 << v.exp_id));
        @(negedge clk);
        chk($sformatf("v%0d enc_data_in", n), 32'(enc_in), 32'(words[v.exp_id]));
        chk($sformatf("v%0d ready_in_run", n), 32'(req_ready), 32'd0);
        chk($sformatf("v%0d busy", n), 32'(busy), 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d early_rsp", n), 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d rsp_valid", n), 32'(rsp_valid), 32'd1);
        chk($sformatf("v%0d rsp_id", n), 32'(rsp_id), 32'(v.exp_id));
        chk($sformatf("v%0d rsp_data", n), 32'(rsp_data), 32'(v.exp_code));
`ifdef ENC_RR_ONEHOT_CHK_EN
        chk($sformatf("v%0d rsp_err", n), 32'(rsp_err), 32'd0);
`endif
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk($sformatf("v%0d hold_valid", n), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d hold_id", n), 32'(rsp_id), 32'(v.exp_id));
            chk($sformatf("v%0d hold_data", n), 32'(rsp_data), 32'(v.exp_code));
            chk($sformatf("v%0d hold_ready", n), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d idle_busy", n), 32'(busy), 32'd0);
    endtask

    initial begin
        words[0] = 4'b0001;
        words[1] = 4'b0010;
        words[2] = 4'b0100;
        words[3] = 4'b1000;

        vecs[0]  = '{4'b1111, 0, 0, 2'b00};
        vecs[1]  = '{4'b1111, 0, 1, 2'b01};
        vecs[2]  = '{4'b1111, 0, 2, 2'b10};
        vecs[3]  = '{4'b1111, 0, 3, 2'b11};
        vecs[4]  = '{4'b1111, 0, 0, 2'b00};
        vecs[5]  = '{4'b0100, 0, 2, 2'b10};
        vecs[6]  = '{4'b0101, 5, 0, 2'b00};
        vecs[7]  = '{4'b0101, 0, 2, 2'b10};
        vecs[8]  = '{4'b1000, 0, 3, 2'b11};
        vecs[9]  = '{4'b0010, 0, 1, 2'b01};
        vecs[10] = '{4'b0011, 0, 0, 2'b00};

        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst enc_data_in", 32'(enc_in), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst rsp_id", 32'(rsp_id), 32'd0);
        chk("rst rsp_data", 32'(rsp_data), 32'd0);
`ifdef ENC_RR_ONEHOT_CHK_EN
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset while the request to requester 2 is in RUN
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        chk("mid req_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        chk("mid busy_run", 32'(busy), 32'd1);
        #2;
        reset     = 1'b1;
        req_valid = 4'b1010;
        #1;
        chk("mid rst req_ready", 32'(req_ready), 32'd0);
        chk("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst enc_data_in", 32'(enc_in), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid rst no_rsp", 32'(rsp_valid), 32'd0);
        end
        reset = 1'b0;
        run_vec('{4'b1010, 0, 1, 2'b01}, 11);

        // Word that is not one-hot
        words[0]  = 4'b0110;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        chk("bad req_ready", 32'(req_ready), 32'b0001);
`ifdef ENC_RR_ONEHOT_CHK_EN
        @(negedge clk);
        chk("bad rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bad rsp_err", 32'(rsp_err), 32'd1);
        chk("bad rsp_data", 32'(rsp_data), 32'd0);
        chk("bad rsp_id", 32'(rsp_id), 32'd0);
        chk("bad enc_data_in", 32'(enc_in), 32'b0010);
        @(negedge clk);
        chk("bad idle", 32'(busy), 32'd0);
`else
        @(negedge clk);
        chk("bad enc_data_in", 32'(enc_in), 32'b0110);
        @(negedge clk);
        chk("bad early_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("bad rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bad rsp_data", 32'(rsp_data), 32'(enc_fn(4'b0110)));
        @(negedge clk);
        chk("bad idle", 32'(busy), 32'd0);
`endif
        req_valid = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/enc_rr_arbiter.md
Name: enc_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered 4-to-2 encoder instance among NUM_REQ requesters.
- Accepts one-hot request words over valid/ready, issues one word at a time to the encoder, and waits out the encoder latency.
- Returns the 2-bit code tagged with the requester ID over a valid/ready response channel.
- Sits between requester agents and the encoder DUT, driving its data_in and sampling its data_out.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DIN_W, 4, encoder input width (one-hot word)
DOUT_W, 2, encoder output width (clog2(DIN_W))
ENC_LAT, 1, encoder latency in clock edges from data_in to data_out (0 = combinational)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_data  in  NUM_REQ*DIN_W  per-requester one-hot word; slice i = bits [i*DIN_W +: DIN_W]
req_ready  out  NUM_REQ  per-requester accept strobe, at most one bit high
enc_data_in  out  DIN_W  registered drive to encoder data_in
enc_data_out  in  DOUT_W  encoder data_out
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  clog2(NUM_REQ)  index of the served requester
rsp_data  out  DOUT_W  captured encoder code
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, ptr=0, req_ready=0, enc_data_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - Winner g = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
  - If a winner exists, req_ready[g]=1 combinationally in this cycle (T). Transfer occurs at the edge ending T.
  - On that edge: enc_data_in <= req_data[g], rsp_id <= g, cnt <= 0, state -> RUN.
  - With no valid request, stay in IDLE; enc_data_in holds its last issued value.
- RUN:
  - Lasts ENC_LAT+1 cycles (T+1 .. T+1+ENC_LAT); cnt increments each cycle.
  - On the edge where cnt==ENC_LAT: rsp_data <= enc_data_out, state -> RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_data stay stable until rsp_ready=1.
  - On the handshake edge: ptr <= (rsp_id+1) mod NUM_REQ, state -> IDLE.
  - First rsp_valid cycle is T+2+ENC_LAT. The next accept is possible in the cycle after the handshake.
- Ordering and throughput:
  - Exactly one transaction in flight; req_ready is 0 in RUN and RESP.
  - Peak throughput is one request per ENC_LAT+3 cycles.
- Fairness: ptr advances only on a completed response. A requester that keeps req_valid high is served again only after every other asserting requester has been served.
- Simultaneous requests: only the round-robin winner is accepted; the others must hold req_valid and req_data stable.
- req_valid dropped before acceptance: no effect, no state change.
- Reset mid-transaction: the in-flight request is silently dropped; no response is produced. After release, arbitration restarts from requester 0.
- ptr and counter wrap modulo their ranges; NUM_REQ not a power of two wraps at NUM_REQ-1 -> 0.

Optional Feature:
Macro ENC_RR_ONEHOT_CHK_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0).
  - At acceptance, a word that is not exactly one-hot (including 0) is not sent to the encoder; enc_data_in is left unchanged and RUN is skipped.
  - Next state is RESP, with rsp_data=0, rsp_err=1 and rsp_valid in T+1.
  - Legal words follow the normal path with rsp_err=0.
- Undefined: no rsp_err port; every word is forwarded to the encoder unchanged and the code returned is whatever the encoder produces.

Decomposition:
- Package enc_rr_pkg:
  - state enum (IDLE, RUN, RESP)
  - localparams ID_W=clog2(NUM_REQ) and CNT_W=clog2(ENC_LAT+1)
  - is_onehot function used by the checker
- One sub-module, enc_rr_picker: combinational round-robin picker with inputs req_valid and ptr, outputs grant_vld and grant_idx. It is verified standalone.

Test Plan:
1. Reset held 4 cycles with req_valid=1111 -> req_ready, rsp_valid, enc_data_in, busy all 0; first grant after release goes to requester 0.
2. ENC_LAT=1, only req_valid[2]=1, req_data[2]=4'b0100, rsp_ready=1 -> req_ready=0100 at T, enc_data_in=0100 from T+1, rsp_valid at T+3 with rsp_id=2, rsp_data=2'b10.
3. All four valid continuously with words 0001/0010/0100/1000 -> service order 0,1,2,3,0, rsp_data 00,01,10,11,00; each new req_ready pulse comes one cycle after the previous response handshake.
4. rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_id, rsp_data stable; req_ready stays 0; ptr unchanged until the handshake.
5. Reset asserted in RUN mid-cycle -> outputs cleared immediately; no response emitted; after release with req_valid=1010, requester 1 is granted first.
6. Macro defined, req_data=0110 -> rsp_err=1, rsp_data=00, rsp_valid at T+1, enc_data_in unchanged. Macro undefined -> encoder receives 0110.
